sel_encoder_32to5: RTL

SEL_ENCODER_32TO5 -- requirements
Module: sel_encoder_32to5

---
 rtl/sel_pkg.sv | 11 +
 rtl/prio_enc_32to5.sv | 17 +
 rtl/sel_encoder_32to5.sv | 45 ++++
 3 files changed

// File: rtl/sel_pkg.sv
// sel_pkg: shared sizes, FSM state type and popcount helper for sel_encoder_32to5
package sel_pkg;
  localparam int NUM_SEL = 32;
  localparam int IDX_W = 5;
  localparam int CNT_W = 6;
  typedef enum logic {IDLE, BUSY} state_t;
  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_SEL-1:0] v);
    popcount = '0;
    for (int i = 0; i < NUM_SEL; i++) popcount += CNT_W'(v[i]);
  endfunction
endpackage

// File: rtl/prio_enc_32to5.sv
// prio_enc_32to5: combinational priority encoder (vector, direction 1=lowest first -> index, any)
module prio_enc_32to5
  import sel_pkg::*;
(
  input  logic [NUM_SEL-1:0] vector,
  input  logic               direction,
  output logic [IDX_W-1:0]   index,
  output logic               any
);
  always_comb begin
    index = '0;
    for (int i = 0; i < NUM_SEL; i++)
      if (vector[direction ? IDX_W'(NUM_SEL - 1 - i) : IDX_W'(i)])
        index = direction ? IDX_W'(NUM_SEL - 1 - i) : IDX_W'(i);
  end
  assign any = |vector;
endmodule

// File: rtl/sel_encoder_32to5.sv
// sel_encoder_32to5: serialises a multi-hot i_select into one o_index per o_valid/i_ready handshake (i_flush discards, o_count = bits left, o_last on final bit)
module sel_encoder_32to5
  import sel_pkg::*;
#(
  parameter bit LSB_FIRST = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NUM_SEL-1:0] i_select,
  output logic               o_ready,
  input  logic               i_flush,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_index,
  output logic               o_last,
  input  logic               i_ready,
  output logic [CNT_W-1:0]   o_count
);
  state_t state;
  logic [NUM_SEL-1:0] pending;
  logic pend_any;
  prio_enc_32to5 u_enc (
    .vector(pending),
    .direction(LSB_FIRST),
    .index(o_index),
    .any(pend_any)
  );
  assign o_ready = state == IDLE && !i_flush;
  assign o_valid = state == BUSY && pend_any;
  assign o_last = o_valid && o_count == CNT_W'(1);
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset || i_flush) begin
      state <= IDLE;
      pending <= '0;
      o_count <= '0;
    end else if (i_valid && o_ready) begin
      pending <= i_select;
      o_count <= popcount(i_select);
      state <= |i_select ? BUSY : IDLE;
    end else if (o_valid && i_ready) begin
      pending <= pending & ~(NUM_SEL'(1) << o_index);
      o_count <= o_count - CNT_W'(1);
      state <= o_last ? IDLE : BUSY;
    end
endmodule
